// File: rtl/periodic_trigger_scheduler.sv
// rtl/periodic_trigger_scheduler.sv - two-channel periodic trigger generator with arbitrated output
//
// Purpose: each channel fires every periodN cycles across a run window. Fires are queued
// as pending bits and offered one at a time on a valid/ready port. Accepted triggers are
// counted per channel. A fire that arrives while its channel is still owed is dropped and
// flagged in a sticky overrun bit.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  pulse; begins a run from IDLE or DONE (ignored in RUN)
//   period0, period1       channel intervals, 0 disables the channel (sampled on start)
//   window                 run length in cycles (sampled on start)
//   trig_valid, trig_id    registered trigger offer and its channel
//   trig_ready             sink accept
//   busy, done             RUN / DONE state indicators
//   count0, count1         saturating accepted-trigger counts
//   overrun                sticky per-channel dropped-fire flags
module periodic_trigger_scheduler #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] period0,
    input  logic [CNT_W-1:0] period1,
    input  logic [WIN_W-1:0] window,
    output logic             trig_valid,
    output logic             trig_id,
    input  logic             trig_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [1:0]       overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [WIN_W-1:0] WIN_ONE = 1;

    logic [1:0]       state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;       // RUN cycles remaining after the current one
    logic [CNT_W-1:0] per0_q, per0_d, per1_q, per1_d;
    logic [CNT_W-1:0] ph0_q, ph0_d, ph1_q, ph1_d;
    logic [1:0]       pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             id_q, id_d;
    logic             rr_q, rr_d;         // channel preferred when both are pending
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [1:0]       ovr_q, ovr_d;

    logic             xfer;
    logic [1:0]       fire, owed, avail;
    logic             grant;

    always_comb begin
        xfer    = valid_q & trig_ready;
        fire[0] = (per0_q != '0) && (ph0_q == '0);
        fire[1] = (per1_q != '0) && (ph1_q == '0);
        // A channel still sitting untransferred in the offer register counts as owed.
        owed[0] = pend_q[0] | (valid_q & ~id_q & ~xfer);
        owed[1] = pend_q[1] | (valid_q &  id_q & ~xfer);
        // Same-cycle fires are eligible for the offer so latency is one cycle.
        avail   = pend_q | (fire & ~owed);
        grant   = (avail == 2'b11) ? rr_q : avail[1];

        state_d = state_q;
        win_d   = win_q;
        per0_d  = per0_q;
        per1_d  = per1_q;
        ph0_d   = ph0_q;
        ph1_d   = ph1_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        id_d    = id_q;
        rr_d    = rr_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        ovr_d   = ovr_q;

        case (state_q)
            S_RUN: begin
                if (fire[0])              ph0_d = per0_q - CNT_ONE;
                else if (per0_q != '0)    ph0_d = ph0_q - CNT_ONE;
                if (fire[1])              ph1_d = per1_q - CNT_ONE;
                else if (per1_q != '0)    ph1_d = ph1_q - CNT_ONE;

                ovr_d = ovr_q | (fire & owed);

                if (xfer) begin
                    if (!id_q && cnt0_q != '1) cnt0_d = cnt0_q + CNT_ONE;
                    if ( id_q && cnt1_q != '1) cnt1_d = cnt1_q + CNT_ONE;
                end

                if (win_q == '0) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    pend_d  = 2'b00;
                end else begin
                    win_d  = win_q - WIN_ONE;
                    pend_d = avail;
                    if (!valid_q || xfer) begin
                        if (avail != 2'b00) begin
                            valid_d = 1'b1;
                            id_d    = grant;
                            pend_d  = avail & (grant ? 2'b01 : 2'b10);
                            rr_d    = ~grant;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    cnt0_d  = '0;
                    cnt1_d  = '0;
                    ovr_d   = 2'b00;
                    pend_d  = 2'b00;
                    valid_d = 1'b0;
                    id_d    = 1'b0;
                    rr_d    = 1'b0;
                    per0_d  = period0;
                    per1_d  = period1;
                    ph0_d   = '0;
                    ph1_d   = '0;
                    if (window != '0) begin
                        state_d = S_RUN;
                        win_d   = window - WIN_ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            per0_q  <= '0;
            per1_q  <= '0;
            ph0_q   <= '0;
            ph1_q   <= '0;
            pend_q  <= 2'b00;
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            ovr_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            per0_q  <= per0_d;
            per1_q  <= per1_d;
            ph0_q   <= ph0_d;
            ph1_q   <= ph1_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            ovr_q   <= ovr_d;
        end
    end

    assign trig_valid = valid_q;
    assign trig_id    = id_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign count0     = cnt0_q;
    assign count1     = cnt1_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_periodic_trigger_scheduler.sv
// tb/tb_periodic_trigger_scheduler.sv - self-checking bench for periodic_trigger_scheduler
module tb_periodic_trigger_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] period0, period1;
    logic [31:0] window;
    logic        trig_valid, trig_id, trig_ready;
    logic        busy, done;
    logic [15:0] count0, count1;
    logic [1:0]  overrun;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_cnt[2];
    bit m_ovr[2];
    bit m_pend[2];
    bit m_v;
    int m_id;
    int m_last;
    int m_p[2];
    int m_w;

    periodic_trigger_scheduler #(.CNT_W(16), .WIN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .period0(period0), .period1(period1), .window(window),
        .trig_valid(trig_valid), .trig_id(trig_id), .trig_ready(trig_ready),
        .busy(busy), .done(done), .count0(count0), .count1(count1), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of RUN cycle k=0 (or first DONE cycle).
    task automatic start_run(input int p0, input int p1, input int w);
        start   = 1'b1;
        period0 = p0[15:0];
        period1 = p1[15:0];
        window  = w;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_ovr[0] = 0; m_ovr[1] = 0;
        m_pend[0] = 0; m_pend[1] = 0;
        m_v = 0; m_id = 0; m_last = 1;
        m_p[0] = p0; m_p[1] = p1; m_w = w;
    endtask

    // One RUN cycle of the specified behaviour: fires occur at multiples of the period.
    task automatic model_step(input int k, input bit rdy);
        bit xfer;
        bit fire[2];
        bit owed[2];
        int pick;
        xfer = m_v && rdy;
        if (xfer && m_cnt[m_id] < 65535) m_cnt[m_id]++;
        for (int c = 0; c < 2; c++) begin
            fire[c] = (m_p[c] != 0) && ((k % m_p[c]) == 0);
            owed[c] = m_pend[c] || (m_v && m_id == c && !xfer);
        end
        for (int c = 0; c < 2; c++)
            if (fire[c]) begin
                if (owed[c]) m_ovr[c] = 1;
                else         m_pend[c] = 1;
            end
        if (k == m_w - 1) begin
            m_v = 0;
            m_pend[0] = 0; m_pend[1] = 0;
        end else if (!m_v || xfer) begin
            if (m_pend[0] && m_pend[1]) pick = 1 - m_last;
            else if (m_pend[0])         pick = 0;
            else if (m_pend[1])         pick = 1;
            else                        pick = -1;
            if (pick < 0) m_v = 0;
            else begin
                m_v = 1; m_id = pick; m_last = pick; m_pend[pick] = 0;
            end
        end
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random. poke_k: cycle to pulse a stray start.
    task automatic run_body(input int rmode, input int poke_k, input int stop_k);
        bit rdy;
        for (int k = 0; k < m_w && k < stop_k; k++) begin
            chk("busy_run", busy, 1'b1);
            chk("valid", trig_valid, m_v);
            if (m_v) chk("id", trig_id, m_id[0]);
            rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
            trig_ready = rdy;
            if (k == poke_k) begin
                start   = 1'b1;
                period0 = 16'($urandom_range(1, 3));
                period1 = 16'($urandom_range(1, 3));
                window  = 32'd3;
            end
            model_step(k, rdy);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_valid"}, trig_valid, 1'b0);
        chk({tag, "_count0"}, count0, m_cnt[0]);
        chk({tag, "_count1"}, count1, m_cnt[1]);
        chk({tag, "_overrun"}, overrun, {m_ovr[1], m_ovr[0]});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; trig_ready = 1'b0;
        period0 = '0; period1 = '0; window = '0;
        #1;
        chk("rst_valid", trig_valid, 1'b0);
        chk("rst_id", trig_id, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count0", count0, 16'd0);
        chk("rst_count1", count1, 16'd0);
        chk("rst_overrun", overrun, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Both channels, always ready
        start_run(20, 40, 200);
        run_body(1, -1, 1 << 30);
        check_done("t1");
        chk("t1_c0_const", count0, 16'd10);
        chk("t1_c1_const", count1, 16'd5);
        chk("t1_ovr_const", overrun, 2'b00);

        // Zero window from DONE with nonzero counts
        start_run(3, 3, 0);
        chk("w0_done", done, 1'b1);
        chk("w0_busy", busy, 1'b0);
        chk("w0_count0", count0, 16'd0);
        chk("w0_count1", count1, 16'd0);
        for (int i = 0; i < 3; i++) begin
            chk("w0_valid", trig_valid, 1'b0);
            @(negedge clk);
        end

        // Period 1 on both channels: alternation and overrun
        start_run(1, 1, 10);
        run_body(1, -1, 1 << 30);
        check_done("t2");
        chk("t2_c0_const", count0, 16'd5);
        chk("t2_c1_const", count1, 16'd4);
        chk("t2_ovr_const", overrun, 2'b11);

        // Sink never ready
        start_run(20, 40, 50);
        run_body(0, -1, 1 << 30);
        check_done("t3");
        chk("t3_ovr_const", overrun, 2'b11);

        // Channel 0 disabled
        start_run(0, 7, 21);
        run_body(1, -1, 1 << 30);
        check_done("t4");
        chk("t4_c1_const", count1, 16'd3);

        // DONE holds while inputs wiggle, then back-to-back run with a stray mid-run start
        for (int i = 0; i < 4; i++) begin
            trig_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_done("hold");
        end
        start_run(5, 0, 10);
        run_body(1, 4, 1 << 30);
        check_done("t5");
        chk("t5_c0_const", count0, 16'd2);
        chk("t5_ovr_const", overrun, 2'b00);

        // Randomized runs with random back-pressure
        for (int r = 0; r < 8; r++) begin
            start_run($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(1, 40));
            run_body(2, (r % 2) ? 2 : -1, 1 << 30);
            check_done("rnd");
        end

        // Asynchronous reset in the middle of a run
        start_run(20, 40, 200);
        run_body(1, -1, 30);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", trig_valid, 1'b0);
        chk("arst_id", trig_id, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_count0", count0, 16'd0);
        chk("arst_count1", count1, 16'd0);
        chk("arst_overrun", overrun, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        trig_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_busy", busy, 1'b0);
            chk("post_done", done, 1'b0);
            chk("post_valid", trig_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/periodic_trigger_scheduler.md
# periodic_trigger_scheduler

Synthesizable two-channel periodic trigger generator with a shared, arbitrated trigger output. Each channel fires at its own programmable interval for the length of a programmable run window. Fires are serialized onto one valid/ready port, and accepted triggers are counted per channel. At window end the block stops, holds its counts and signals done. It sits between the test sequencer (start/config) and any single-consumer event sink that must be shared by two periodic sources.

## Interface
Parameters:
- CNT_W, 16, width of period inputs and trigger counters
- WIN_W, 32, width of run-window length

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- period0  in  CNT_W  channel 0 interval in cycles; sampled on accepted start; 0 = channel disabled
- period1  in  CNT_W  channel 1 interval; same rules
- window  in  WIN_W  run length in cycles; sampled on accepted start
- trig_valid  out  1  trigger offered (registered)
- trig_id  out  1  channel of offered trigger (registered)
- trig_ready  in  1  sink accepts; transfer = trig_valid & trig_ready at rising edge
- busy  out  1  high in RUN
- done  out  1  high in DONE (level)
- count0  out  CNT_W  accepted triggers, channel 0
- count1  out  CNT_W  accepted triggers, channel 1
- overrun  out  2  sticky per-channel dropped-fire flag

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + start:
  - window ≠ 0 → RUN. Counts, overrun, pending, offer and the round-robin pointer are cleared.
  - window = 0 → DONE. Counts are 0.
- start while in RUN is ignored.
- RUN cycle index k = 0 .. window−1, where k = 0 is the first RUN cycle.
  - An enabled channel with period P fires at k = 0, P, 2P, ….
  - Each channel has a phase down-counter, reloaded with P−1 on each fire.
- Owed channel: a channel is owed if its pending bit is set, or if it is in the offer register and not transferred this cycle.
- Fire of a channel that is not owed sets its pending bit.
- Fire of an owed channel is dropped: not counted, and its overrun bit is set (sticky until the next start).
- Offer register loads at an edge where trig_valid = 0 or a transfer occurs.
  - It selects among pending channels and clears the selected pending bit.
  - With one pending channel, that channel is taken.
  - With both pending, round-robin: the channel not granted last is taken. The pointer resets so that channel 0 wins first.
  - With nothing pending, trig_valid goes to 0.
- trig_id is stable while trig_valid = 1 and trig_ready = 0; an offer is never withdrawn in RUN.
- On transfer: count[trig_id] increments, saturating at 2^CNT_W−1.
- Window end: the edge ending k = window−1 moves RUN → DONE.
  - A transfer on that edge counts.
  - Pending bits and the offer are discarded; trig_valid = 0 in DONE.
- DONE holds count0/count1/overrun until start.
- Async reset at any time forces IDLE and zeroes all state immediately.

## Timing
- Reset values: trig_valid 0, trig_id 0, busy 0, done 0, count0 0, count1 0, overrun 2'b00.
- Start accepted at edge e → busy = 1 from the cycle after e; that cycle is k = 0.
- Fire at k → earliest trig_valid in cycle k+1 (latency 1). A simultaneous second fire is offered no earlier than k+2.
- Throughput: at most one transfer per cycle.
- busy falls and done rises in the same cycle, window cycles after k = 0.

## Test plan
- P0=20, P1=40, window=200, trig_ready=1 → both fire at k=0.
  - ch0 offered k=1, ch1 offered k=2.
  - Last offer (ch0) at k=181.
  - done at k=200: count0=10, count1=5, overrun=00.
- P0=1, P1=1, window=10, trig_ready=1 → trig_id alternates 0,1,0,… on k=1..9.
  - Result: count0=5, count1=4, overrun=11.
- P0=20, P1=40, window=50, trig_ready=0 → ch0 offered from k=1 and held; ch1 pending.
  - Fires at k=20/40 (ch0) and k=40 (ch1) overrun.
  - Result: count0=0, count1=0, overrun=11; trig_valid=0 in DONE.
- P0=0, P1=7, window=21, trig_ready=1 → count0=0, count1=3.
  - Second test: start with window=0 → DONE next cycle, counts 0, trig_valid never high.
- Back-to-back runs: complete run 1 and hold DONE, then start with P0=5, window=10 → counts and overrun cleared, count0=2.
  - Second test: start pulsed mid-RUN is ignored.
- Reset mid-run: assert rst_n=0 at k=30 of run 1 → all outputs at reset values asynchronously.
  - After release, state is IDLE until start.
